hilo_div_unit: RTL and testbench

- Multi-cycle 32-bit divider executing MIPS DIV/DIVU.
- Sits beside the EX stage.
- Produces the remainder for HI and the quotient for LO, plus a one-cycle write strobe that drives the HI/LO register write port.
- EX stalls the pipeline while o_busy is high.

---
 rtl/hilo_div_unit.sv | 172 +++++++++++++++++
 tb/tb_hilo_div_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: multi-cycle restoring divider for MIPS DIV/DIVU.
// Produces the remainder on o_hi and the quotient on o_lo, with a one-cycle
// o_ready strobe that doubles as the HI/LO write enable.
//
// Handshake: a request is taken when i_start=1 and i_annul=0 while the unit
// is IDLE (o_busy=0). From the next cycle o_busy stays high until the cycle
// after o_ready. o_ready is a single-cycle pulse with o_hi/o_lo valid in that
// same cycle; there is no back-pressure. i_annul drops an in-flight request
// (BYZERO/RUN) without a strobe. i_start outside IDLE is ignored.
module hilo_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_annul,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [1:0]       o_state
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    // Operand magnitudes and signs seen at acceptance
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One restoring step: trial-subtract the divisor from {rem, next dividend bit}
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] rem_step, quo_step;

    // Datapath for operand capture and a single division iteration
    always_comb begin
        a_neg    = i_signed & i_dividend[WIDTH-1];
        b_neg    = i_signed & i_divisor[WIDTH-1];
        a_mag    = a_neg ? (~i_dividend + 1'b1) : i_dividend;
        b_mag    = b_neg ? (~i_divisor + 1'b1) : i_divisor;
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, dvs_q};
        fits     = ~diff[WIDTH+1];
        rem_step = fits ? WIDTH'(diff) : WIDTH'(shifted);
        quo_step = {dvd_q[WIDTH-2:0], fits};
    end

    // Next-state and register update decisions for the divider FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ready_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_annul) begin
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    rem_d   = '0;
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    state_d = (i_divisor == '0) ? S_BYZERO : S_RUN;
                end
            end
            S_BYZERO: begin
                if (i_annul) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    hi_d    = '0;
                    lo_d    = '0;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                if (i_annul) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    dvd_d = quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        lo_d    = qneg_q ? (~quo_step + 1'b1) : quo_step;
                        hi_d    = rneg_q ? (~rem_step + 1'b1) : rem_step;
                        ready_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_ready = ready_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Testbench for hilo_div_unit: directed and randomized divisions checked
// against a plain-arithmetic reference model.
module tb_hilo_div_unit;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_annul;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_busy;
    logic        o_ready;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic [1:0]  o_state;

    int errors = 0;
    int checks = 0;

    // Last completed result, which HI/LO must hold across annul
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    hilo_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_annul    (i_annul),
        .i_signed   (i_signed),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_busy     (o_busy),
        .o_ready    (o_ready),
        .o_hi       (o_hi),
        .o_lo       (o_lo),
        .o_state    (o_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: MIPS DIV/DIVU with truncation toward zero, div-by-zero gives 0/0
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic sgn, output logic [31:0] q,
                                    output logic [31:0] r);
        longint sa, sb;
        if (b == 32'h0) begin
            q = 32'h0;
            r = 32'h0;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Driver: issue one request and observe it until o_busy drops.
    // k counts edges after acceptance; annul_at / restart_at pulse those inputs at sample k.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int annul_at, input int restart_at,
                           output logic [31:0] hi, output logic [31:0] lo,
                           output int pulses, output int lat, output int busy_cyc,
                           output logic timeout);
        hi = 32'h0; lo = 32'h0; pulses = 0; lat = -1; busy_cyc = 0; timeout = 1'b1;
        i_start = 1'b1; i_annul = 1'b0; i_signed = sgn; i_dividend = a; i_divisor = b;
        @(posedge clk); #1;
        i_start = 1'b0; i_signed = $urandom_range(0, 1);
        i_dividend = $urandom; i_divisor = $urandom;
        for (int k = 0; k < 100; k++) begin
            if (o_busy) busy_cyc++;
            if (o_ready) begin
                pulses++;
                lat = k;
                hi = o_hi;
                lo = o_lo;
            end
            if (!o_busy) begin
                timeout = 1'b0;
                break;
            end
            i_start = (k == restart_at);
            if (k == restart_at) begin
                i_dividend = 32'd9; i_divisor = 32'd4; i_signed = 1'b0;
            end
            i_annul = (k == annul_at);
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        i_annul = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", o_hi); end
        checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", o_lo); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_directed();
        logic [31:0] ta[6]  = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd123};
        logic [31:0] tb[6]  = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd0};
        logic        ts[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] tlo[6] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        logic [31:0] thi[6] = '{32'd2, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0};
        logic [31:0] hi, lo;
        int pulses, lat, busy_cyc, exp_lat, exp_busy;
        logic to;
        for (int i = 0; i < 6; i++) begin
            run_div(ta[i], tb[i], ts[i], -1, -1, hi, lo, pulses, lat, busy_cyc, to);
            exp_lat  = (tb[i] == 32'h0) ? 1 : 32;
            exp_busy = (tb[i] == 32'h0) ? 2 : 33;
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL dir_timeout[%0d] got=%b exp=0", i, to); end
            checks++; if (lo !== tlo[i]) begin errors++; $display("FAIL dir_lo[%0d] got=%h exp=%h", i, lo, tlo[i]); end
            checks++; if (hi !== thi[i]) begin errors++; $display("FAIL dir_hi[%0d] got=%h exp=%h", i, hi, thi[i]); end
            checks++; if (pulses != 1) begin errors++; $display("FAIL dir_pulses[%0d] got=%0d exp=1", i, pulses); end
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
            checks++; if (busy_cyc != exp_busy) begin errors++; $display("FAIL dir_busy_cycles[%0d] got=%0d exp=%0d", i, busy_cyc, exp_busy); end
            checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL dir_state_idle[%0d] got=%0d exp=0", i, o_state); end
            exp_hi = thi[i];
            exp_lo = tlo[i];
        end
    endtask

    // Random requests issued back to back, each accepted in the IDLE cycle after DONE
    task automatic test_random_back_to_back();
        logic [31:0] a, b, hi, lo, eq, er;
        logic sgn, to;
        int pulses, lat, busy_cyc, sel;
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = $urandom_range(1, 15);
                4: a = $urandom_range(0, 100);
                default: ;
            endcase
            ref_div(a, b, sgn, eq, er);
            run_div(a, b, sgn, -1, -1, hi, lo, pulses, lat, busy_cyc, to);
            checks++; if (lo !== eq) begin errors++; $display("FAIL rnd_lo[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, sgn, lo, eq); end
            checks++; if (hi !== er) begin errors++; $display("FAIL rnd_hi[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, sgn, hi, er); end
            checks++; if (pulses != 1 || to !== 1'b0) begin errors++; $display("FAIL rnd_pulses[%0d] got=%0d timeout=%b exp=1", i, pulses, to); end
            exp_hi = er;
            exp_lo = eq;
        end
    endtask

    task automatic test_annul();
        logic [31:0] hi, lo;
        logic to;
        int pulses, lat, busy_cyc;
        // Annul in RUN cycle 10, with an ignored restart at cycle 5
        run_div(32'd100, 32'd7, 1'b0, 10, 5, hi, lo, pulses, lat, busy_cyc, to);
        checks++; if (pulses != 0) begin errors++; $display("FAIL annul_run_pulses got=%0d exp=0", pulses); end
        checks++; if (busy_cyc != 11) begin errors++; $display("FAIL annul_run_busy got=%0d exp=11", busy_cyc); end
        checks++; if (o_hi !== exp_hi) begin errors++; $display("FAIL annul_run_hi got=%h exp=%h", o_hi, exp_hi); end
        checks++; if (o_lo !== exp_lo) begin errors++; $display("FAIL annul_run_lo got=%h exp=%h", o_lo, exp_lo); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL annul_run_state got=%0d exp=0", o_state); end
        // Immediate new request
        run_div(32'd9, 32'd4, 1'b0, -1, -1, hi, lo, pulses, lat, busy_cyc, to);
        checks++; if (lo !== 32'd2 || hi !== 32'd1) begin errors++; $display("FAIL annul_next got=%h/%h exp=00000002/00000001", lo, hi); end
        checks++; if (pulses != 1 || lat != 32) begin errors++; $display("FAIL annul_next_timing got=%0d/%0d exp=1/32", pulses, lat); end
        exp_hi = 32'd1; exp_lo = 32'd2;
        // Annul on the last RUN cycle
        run_div(32'd1000, 32'd3, 1'b0, 31, -1, hi, lo, pulses, lat, busy_cyc, to);
        checks++; if (pulses != 0) begin errors++; $display("FAIL annul_last_pulses got=%0d exp=0", pulses); end
        checks++; if (o_lo !== exp_lo || o_hi !== exp_hi) begin errors++; $display("FAIL annul_last_hold got=%h/%h exp=%h/%h", o_lo, o_hi, exp_lo, exp_hi); end
        // Annul in BYZERO
        run_div(32'd123, 32'd0, 1'b1, 0, -1, hi, lo, pulses, lat, busy_cyc, to);
        checks++; if (pulses != 0 || busy_cyc != 1) begin errors++; $display("FAIL annul_byzero got=%0d/%0d exp=0/1", pulses, busy_cyc); end
        checks++; if (o_lo !== exp_lo || o_hi !== exp_hi) begin errors++; $display("FAIL annul_byzero_hold got=%h/%h exp=%h/%h", o_lo, o_hi, exp_lo, exp_hi); end
        // Annul in DONE does not cancel the strobe
        run_div(32'd50, 32'd5, 1'b0, 32, -1, hi, lo, pulses, lat, busy_cyc, to);
        checks++; if (pulses != 1 || lo !== 32'd10 || hi !== 32'd0) begin errors++; $display("FAIL annul_done got=%0d %h/%h exp=1 0000000a/00000000", pulses, lo, hi); end
        exp_hi = 32'd0; exp_lo = 32'd10;
    endtask

    task automatic test_ignored_start();
        logic [31:0] hi, lo;
        logic to;
        int pulses, lat, busy_cyc;
        // Restart during RUN must not disturb the running division
        run_div(32'd100, 32'd7, 1'b0, -1, 5, hi, lo, pulses, lat, busy_cyc, to);
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL ign_run got=%h/%h exp=0000000e/00000002", lo, hi); end
        checks++; if (pulses != 1 || busy_cyc != 33) begin errors++; $display("FAIL ign_run_timing got=%0d/%0d exp=1/33", pulses, busy_cyc); end
        // Restart during DONE is ignored, not queued
        run_div(32'd77, 32'd7, 1'b0, -1, 32, hi, lo, pulses, lat, busy_cyc, to);
        checks++; if (lo !== 32'd11 || hi !== 32'd0 || pulses != 1) begin errors++; $display("FAIL ign_done got=%h/%h p=%0d exp=0000000b/00000000 p=1", lo, hi, pulses); end
        @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0 || o_state !== 2'd0) begin errors++; $display("FAIL ign_done_idle got=%b/%0d exp=0/0", o_busy, o_state); end
        exp_hi = 32'd0; exp_lo = 32'd11;
        // Start together with annul in IDLE is ignored
        i_start = 1'b1; i_annul = 1'b1; i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7;
        @(posedge clk); #1;
        i_start = 1'b0; i_annul = 1'b0;
        checks++; if (o_busy !== 1'b0 || o_state !== 2'd0) begin errors++; $display("FAIL start_annul got=%b/%0d exp=0/0", o_busy, o_state); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] hi, lo;
        logic to;
        int pulses, lat, busy_cyc, seen;
        i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0 || o_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got=%b/%b exp=0/0", o_busy, o_ready); end
        checks++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin errors++; $display("FAIL rst_mid_data got=%h/%h exp=0/0", o_hi, o_lo); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_mid_state got=%0d exp=0", o_state); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_ready || o_busy) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_quiet got=%0d exp=0", seen); end
        run_div(32'd50, 32'd5, 1'b0, -1, -1, hi, lo, pulses, lat, busy_cyc, to);
        checks++; if (lo !== 32'd10 || hi !== 32'd0 || pulses != 1) begin errors++; $display("FAIL rst_after got=%h/%h p=%0d exp=0000000a/00000000 p=1", lo, hi, pulses); end
    endtask

    // Test sequence
    initial begin
        rst = 1'b0;
        i_start = 1'b0;
        i_annul = 1'b0;
        i_signed = 1'b0;
        i_dividend = 32'h0;
        i_divisor = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_annul();
        test_ignored_start();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
